// File: rtl/meas_accbuf_if.sv
// Bus bundle for meas_accbuf: arm/trigger controls, per-channel results,
// readout port and per-channel status.
//
// Handshake: each done[i] is a one-cycle valid strobe with no ready. It
// qualifies the matching xacc/yacc slices in that cycle only. A result offered
// while its channel cannot take it (push busy or buffer full) is dropped, and
// the drop is recorded in the sticky overflow[i] flag.
interface meas_accbuf_if #(
  parameter int NCHAN = 4,
  parameter int DW    = 32,
  parameter int AW    = 12,
  parameter int CHW   = 2
);
  logic                    start;
  logic                    trig;
  logic                    wrap;
  logic [NCHAN-1:0]        done;
  logic [NCHAN*DW-1:0]     xacc;
  logic [NCHAN*DW-1:0]     yacc;
  logic [CHW-1:0]          rd_chan;
  logic [AW-1:0]           rd_addr;
  logic [DW-1:0]           rd_data;
  logic [NCHAN-1:0]        full;
  logic [NCHAN*(AW+1)-1:0] count;
  logic [NCHAN-1:0]        overflow;
  logic                    armed;
  // Debug view of each channel FSM, 2 bits per channel (IDLE/WAIT/RUN/FULL).
  logic [NCHAN*2-1:0]      state;

  modport master (
    output start, trig, wrap, done, xacc, yacc, rd_chan, rd_addr,
    input  rd_data, full, count, overflow, armed, state
  );

  modport slave (
    input  start, trig, wrap, done, xacc, yacc, rd_chan, rd_addr,
    output rd_data, full, count, overflow, armed, state
  );
endinterface

// File: rtl/meas_accbuf.sv
// Multi-channel measurement capture buffer. Each channel arms on start,
// begins capturing on trig, and stores each X/Y result pair as two
// consecutive words in its own buffer, either stopping when full or wrapping.
module meas_accbuf #(
  parameter int NCHAN = 4,
  parameter int DW    = 32,
  parameter int AW    = 12,
  parameter int CHW   = 2
) (
  input  logic          clk,
  input  logic          reset,
  meas_accbuf_if.slave  bus
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   CNT_MAX   = (AW+1)'(DEPTH);
  // A push starting here fills the last two words of the buffer.
  localparam logic [AW-1:0] LAST_PAIR = AW'(DEPTH - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2,
    S_FULL = 2'd3
  } state_t;

  state_t            state_q [NCHAN];
  state_t            state_d [NCHAN];
  logic [AW-1:0]     ptr_q   [NCHAN];
  logic [AW-1:0]     ptr_d   [NCHAN];
  logic [AW:0]       cnt_q   [NCHAN];
  logic [AW:0]       cnt_d   [NCHAN];
  logic [DW-1:0]     yhold_q [NCHAN];
  logic [DW-1:0]     yhold_d [NCHAN];
  logic [NCHAN-1:0]  full_q, full_d;
  logic [NCHAN-1:0]  ovf_q, ovf_d;
  // ph2 marks the second (Y write) cycle of a push in progress.
  logic [NCHAN-1:0]  ph2_q, ph2_d;
  logic [NCHAN-1:0]  wrap_q, wrap_d;

  logic [NCHAN-1:0]  we;
  logic [AW-1:0]     waddr [NCHAN];
  logic [DW-1:0]     wdata [NCHAN];

  logic [DW-1:0]     mem [NCHAN][DEPTH];
  logic [DW-1:0]     rd_data_q;

  function automatic logic [AW:0] cnt_inc(input logic [AW:0] c);
    return (c == CNT_MAX) ? c : c + (AW+1)'(1);
  endfunction

  // Per-channel next-state, push sequencing and memory write request.
  always_comb begin
    for (int i = 0; i < NCHAN; i++) begin
      state_d[i] = state_q[i];
      ptr_d[i]   = ptr_q[i];
      cnt_d[i]   = cnt_q[i];
      yhold_d[i] = yhold_q[i];
      full_d[i]  = full_q[i];
      ovf_d[i]   = ovf_q[i];
      ph2_d[i]   = ph2_q[i];
      wrap_d[i]  = wrap_q[i];
      we[i]      = 1'b0;
      waddr[i]   = ptr_q[i];
      wdata[i]   = bus.xacc[i*DW +: DW];

      if (bus.start) begin
        // start overrides everything, including a pending Y write.
        state_d[i] = S_WAIT;
        ptr_d[i]   = '0;
        cnt_d[i]   = '0;
        full_d[i]  = 1'b0;
        ovf_d[i]   = 1'b0;
        ph2_d[i]   = 1'b0;
      end else begin
        case (state_q[i])
          S_IDLE: ;
          S_WAIT: begin
            if (bus.trig) state_d[i] = S_RUN;
          end
          S_RUN: begin
            if (ph2_q[i]) begin
              we[i]    = 1'b1;
              waddr[i] = ptr_q[i] + AW'(1);
              wdata[i] = yhold_q[i];
              ph2_d[i] = 1'b0;
              ptr_d[i] = ptr_q[i] + AW'(2);
              cnt_d[i] = cnt_inc(cnt_q[i]);
              if (bus.done[i]) ovf_d[i] = 1'b1;
              if (!wrap_q[i] && ptr_q[i] == LAST_PAIR) begin
                state_d[i] = S_FULL;
                full_d[i]  = 1'b1;
              end
            end else if (bus.done[i]) begin
              we[i]      = 1'b1;
              ph2_d[i]   = 1'b1;
              yhold_d[i] = bus.yacc[i*DW +: DW];
              wrap_d[i]  = bus.wrap;
              cnt_d[i]   = cnt_inc(cnt_q[i]);
            end
          end
          S_FULL: begin
            if (bus.done[i]) ovf_d[i] = 1'b1;
          end
          default: state_d[i] = S_IDLE;
        endcase
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCHAN; i++) begin
        state_q[i] <= S_IDLE;
        ptr_q[i]   <= '0;
        cnt_q[i]   <= '0;
        yhold_q[i] <= '0;
      end
      full_q <= '0;
      ovf_q  <= '0;
      ph2_q  <= '0;
      wrap_q <= '0;
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        state_q[i] <= state_d[i];
        ptr_q[i]   <= ptr_d[i];
        cnt_q[i]   <= cnt_d[i];
        yhold_q[i] <= yhold_d[i];
      end
      full_q <= full_d;
      ovf_q  <= ovf_d;
      ph2_q  <= ph2_d;
      wrap_q <= wrap_d;
    end
  end

  // Buffer storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCHAN; i++) begin
      if (we[i]) mem[i][waddr[i]] <= wdata[i];
    end
  end

  // Registered readout; same-cycle writes are not forwarded (old data).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if ({1'b0, bus.rd_chan} < (CHW+1)'(NCHAN)) begin
      rd_data_q <= mem[bus.rd_chan][bus.rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

  // Pack per-channel status onto the bus.
  always_comb begin
    bus.count = '0;
    bus.state = '0;
    bus.armed = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      bus.count[i*(AW+1) +: (AW+1)] = cnt_q[i];
      bus.state[i*2 +: 2]           = state_q[i];
      if (state_q[i] == S_WAIT) bus.armed = 1'b1;
    end
    bus.full     = full_q;
    bus.overflow = ovf_q;
    bus.rd_data  = rd_data_q;
  end

endmodule

// File: tb/tb_meas_accbuf.sv
// Directed bench for meas_accbuf (NCHAN=4, DW=32, AW=4). Reads push their
// expected word into exp_q; a monitor compares when the registered read
// data is presented. Status flags are compared against constants.
module tb_meas_accbuf;
  localparam int NCHAN = 4;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int CHW   = 2;

  logic clk = 1'b0;
  logic reset;

  // Clock generation.
  always #5 clk = ~clk;

  meas_accbuf_if #(.NCHAN(NCHAN), .DW(DW), .AW(AW), .CHW(CHW)) bus();

  meas_accbuf #(.NCHAN(NCHAN), .DW(DW), .AW(AW), .CHW(CHW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];
  string         tag_q[$];
  logic          rd_req = 1'b0;
  logic          rd_vld;

  // Track which cycles carry a requested read result.
  always @(posedge clk or posedge reset) begin
    if (reset) rd_vld <= 1'b0;
    else       rd_vld <= rd_req;
  end

  // Monitor: compare presented read data with the scoreboard head.
  always @(negedge clk) begin
    if (rd_vld) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: got %h, nothing expected", bus.rd_data);
      end else begin
        logic [DW-1:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (bus.rd_data !== e) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", t, bus.rd_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] cnt_of(input int ch);
    return 32'(bus.count[ch*(AW+1) +: (AW+1)]);
  endfunction

  function automatic logic [31:0] st_of(input int ch);
    return 32'(bus.state[ch*2 +: 2]);
  endfunction

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_trig();
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
  endtask

  task automatic push(input int ch, input logic [DW-1:0] x, input logic [DW-1:0] y);
    bus.done[ch]            = 1'b1;
    bus.xacc[ch*DW +: DW]   = x;
    bus.yacc[ch*DW +: DW]   = y;
    tick();
    bus.done[ch] = 1'b0;
    tick();
    tick();
  endtask

  task automatic rd(input int ch, input int addr, input logic [DW-1:0] e, input string t);
    bus.rd_chan = CHW'(ch);
    bus.rd_addr = AW'(addr);
    rd_req      = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(t);
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.trig    = 1'b0;
    bus.wrap    = 1'b0;
    bus.done    = '0;
    bus.xacc    = '0;
    bus.yacc    = '0;
    bus.rd_chan = '0;
    bus.rd_addr = '0;
    repeat (3) tick();

    // Reset state.
    check("rst_full",     32'(bus.full), 0);
    check("rst_count",    32'(bus.count), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_armed",    32'(bus.armed), 0);
    check("rst_rd_data",  bus.rd_data, 0);
    check("rst_state",    32'(bus.state), 0);
    reset = 1'b0;
    tick();

    // Basic push on channel 0.
    pulse_start();
    check("basic_armed_after_start", 32'(bus.armed), 1);
    check("basic_state0_wait", st_of(0), 1);
    pulse_trig();
    check("basic_armed_after_trig", 32'(bus.armed), 0);
    push(0, 32'h1111_1111, 32'h2222_2222);
    check("basic_count0", cnt_of(0), 2);
    check("basic_count1", cnt_of(1), 0);
    check("basic_count2", cnt_of(2), 0);
    check("basic_count3", cnt_of(3), 0);
    rd(0, 0, 32'h1111_1111, "basic_ch0_a0");
    rd(0, 1, 32'h2222_2222, "basic_ch0_a1");

    // Stop mode on channel 2.
    bus.wrap = 1'b0;
    pulse_start();
    pulse_trig();
    for (int k = 0; k < 7; k++) push(2, 32'hA000_0000 + 32'(k), 32'hB000_0000 + 32'(k));
    check("stop_count2_before_last", cnt_of(2), 14);
    check("stop_full2_before_last", 32'(bus.full[2]), 0);
    push(2, 32'hA000_0007, 32'hB000_0007);
    check("stop_full2", 32'(bus.full[2]), 1);
    check("stop_count2", cnt_of(2), 16);
    check("stop_state2_full", st_of(2), 3);
    check("stop_ovf2_clear", 32'(bus.overflow[2]), 0);
    push(2, 32'hEEEE_EEEE, 32'hFFFF_FFFF);
    check("stop_ovf2_set", 32'(bus.overflow[2]), 1);
    check("stop_count2_after_ovf", cnt_of(2), 16);
    for (int k = 0; k < 8; k++) begin
      rd(2, 2*k,   32'hA000_0000 + 32'(k), $sformatf("stop_x%0d", k));
      rd(2, 2*k+1, 32'hB000_0000 + 32'(k), $sformatf("stop_y%0d", k));
    end
    rd(0, 0, 32'h1111_1111, "stop_ch0_kept");

    // Circular mode on channel 1.
    bus.wrap = 1'b1;
    pulse_start();
    pulse_trig();
    for (int k = 1; k <= 8; k++) push(1, 32'hC000_0000 + 32'(k), 32'hD000_0000 + 32'(k));
    // Ninth push writes addr0 while addr0 is read in the same cycle.
    bus.done[1]            = 1'b1;
    bus.xacc[1*DW +: DW]   = 32'hC000_0009;
    bus.yacc[1*DW +: DW]   = 32'hD000_0009;
    bus.rd_chan            = 2'd1;
    bus.rd_addr            = '0;
    rd_req                 = 1'b1;
    exp_q.push_back(32'hC000_0001);
    tag_q.push_back("circ_same_cycle_old");
    tick();
    bus.done[1] = 1'b0;
    rd_req      = 1'b0;
    tick();
    tick();
    check("circ_count1", cnt_of(1), 16);
    check("circ_full1", 32'(bus.full[1]), 0);
    check("circ_ovf1", 32'(bus.overflow[1]), 0);
    check("circ_state1_run", st_of(1), 2);
    rd(1, 0, 32'hC000_0009, "circ_a0");
    rd(1, 1, 32'hD000_0009, "circ_a1");
    rd(1, 2, 32'hC000_0002, "circ_a2");
    bus.wrap = 1'b0;

    // Back-to-back done on channel 3.
    pulse_start();
    pulse_trig();
    bus.done[3]          = 1'b1;
    bus.xacc[3*DW +: DW] = 32'h3131_3131;
    bus.yacc[3*DW +: DW] = 32'h3232_3232;
    tick();
    bus.xacc[3*DW +: DW] = 32'h4141_4141;
    bus.yacc[3*DW +: DW] = 32'h4242_4242;
    tick();
    bus.done[3] = 1'b0;
    tick();
    tick();
    check("b2b_count3", cnt_of(3), 2);
    check("b2b_ovf3", 32'(bus.overflow[3]), 1);
    rd(3, 0, 32'h3131_3131, "b2b_a0");
    rd(3, 1, 32'h3232_3232, "b2b_a1");

    // Precedence: done before trig, done with trig.
    pulse_start();
    bus.done[0]          = 1'b1;
    bus.xacc[0*DW +: DW] = 32'hDEAD_BEEF;
    bus.yacc[0*DW +: DW] = 32'hBAD0_BAD0;
    tick();
    bus.done[0] = 1'b0;
    tick();
    check("prec_wait_done_count0", cnt_of(0), 0);
    bus.trig    = 1'b1;
    bus.done[0] = 1'b1;
    tick();
    bus.trig    = 1'b0;
    bus.done[0] = 1'b0;
    tick();
    check("prec_trig_done_count0", cnt_of(0), 0);
    check("prec_state0_run", st_of(0), 2);
    rd(0, 0, 32'h1111_1111, "prec_no_write_a0");
    rd(0, 1, 32'h2222_2222, "prec_no_write_a1");
    push(0, 32'h3333_3333, 32'h4444_4444);
    check("prec_push_count0", cnt_of(0), 2);

    // start coincident with done mid-run.
    pulse_start();
    pulse_trig();
    bus.start            = 1'b1;
    bus.done[0]          = 1'b1;
    bus.xacc[0*DW +: DW] = 32'h5555_5555;
    bus.yacc[0*DW +: DW] = 32'h5656_5656;
    tick();
    bus.start   = 1'b0;
    bus.done[0] = 1'b0;
    tick();
    check("prec_start_done_count0", cnt_of(0), 0);
    check("prec_start_done_state0", st_of(0), 1);
    check("prec_start_done_armed", 32'(bus.armed), 1);
    check("prec_start_done_ovf0", 32'(bus.overflow[0]), 0);
    rd(0, 0, 32'h3333_3333, "prec_start_done_a0");

    // start during the Y cycle aborts the Y write.
    pulse_trig();
    bus.done[0]          = 1'b1;
    bus.xacc[0*DW +: DW] = 32'h6666_6666;
    bus.yacc[0*DW +: DW] = 32'h7777_7777;
    tick();
    bus.done[0] = 1'b0;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("prec_start_ph2_count0", cnt_of(0), 0);
    check("prec_start_ph2_ovf0", 32'(bus.overflow[0]), 0);
    rd(0, 0, 32'h6666_6666, "prec_start_ph2_a0");
    rd(0, 1, 32'h4444_4444, "prec_start_ph2_a1");

    // Reset during the Y cycle aborts the Y write; memory is kept.
    pulse_trig();
    bus.done[0]          = 1'b1;
    bus.xacc[0*DW +: DW] = 32'h8888_8888;
    bus.yacc[0*DW +: DW] = 32'h9999_9999;
    tick();
    bus.done[0] = 1'b0;
    reset       = 1'b1;
    #1;
    check("midrst_count0", cnt_of(0), 0);
    check("midrst_state0", st_of(0), 0);
    check("midrst_armed", 32'(bus.armed), 0);
    tick();
    reset = 1'b0;
    tick();
    rd(0, 0, 32'h8888_8888, "midrst_a0");
    rd(0, 1, 32'h4444_4444, "midrst_a1");

    // Let the monitor drain outstanding reads, bounded.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
